// File: rtl/rx_frame_assembler.sv
// rtl/rx_frame_assembler.sv - RX serial bit packer with parametrised serial CRC and frame status
module rx_frame_assembler #(
    parameter int WORD_WIDTH = 8,
    parameter int MAX_BITS = 512,
    parameter int CRC_WIDTH = 16,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY = 16'h1021,
    parameter logic [CRC_WIDTH-1:0] CRC_INIT = 16'hFFFF,
    parameter logic [CRC_WIDTH-1:0] CRC_RESIDUE = 16'h1D0F,
    localparam int NB_W = $clog2(WORD_WIDTH + 1),
    localparam int LEN_W = $clog2(MAX_BITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sof,
    input  logic                  eof,
    input  logic                  in_dat,
    input  logic                  in_vld,
    output logic [WORD_WIDTH-1:0] out_dat,
    output logic [NB_W-1:0]       out_nbits,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic                  frame_done,
    output logic [LEN_W-1:0]      frame_len,
    output logic                  crc_ok,
    output logic                  err_len,
    output logic                  err_overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [WORD_WIDTH-1:0] shreg;
    logic [WORD_WIDTH-1:0] shreg_next;
    logic [NB_W-1:0]       bit_cnt;
    logic [NB_W-1:0]       bit_cnt_next;
    logic [CRC_WIDTH-1:0]  crc;
    logic [CRC_WIDTH-1:0]  crc_next;
    logic [CRC_WIDTH-1:0]  crc_final;
    logic                  crc_fb;
    logic                  accept;
    logic                  word_full;
    logic                  slot_free;

    always_comb begin
        slot_free    = !out_vld || out_rdy;
        accept       = (state == S_RECV) && in_vld && (frame_len < LEN_W'(MAX_BITS));
        word_full    = accept && (bit_cnt == NB_W'(WORD_WIDTH - 1));
        shreg_next   = {shreg[WORD_WIDTH-2:0], in_dat};
        crc_fb       = crc[CRC_WIDTH-1] ^ in_dat;
        crc_next     = {crc[CRC_WIDTH-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);
        // eof-cycle bit is folded in before the frame is closed
        crc_final    = accept ? crc_next : crc;
        bit_cnt_next = word_full ? '0 : (accept ? bit_cnt + NB_W'(1) : bit_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            crc         <= CRC_INIT;
            out_dat     <= '0;
            out_nbits   <= '0;
            out_vld     <= 1'b0;
            frame_done  <= 1'b0;
            frame_len   <= '0;
            crc_ok      <= 1'b0;
            err_len     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end
            if (sof) begin
                state       <= S_RECV;
                shreg       <= '0;
                bit_cnt     <= '0;
                crc         <= CRC_INIT;
                frame_len   <= '0;
                crc_ok      <= 1'b0;
                err_len     <= 1'b0;
                err_overrun <= 1'b0;
                out_vld     <= 1'b0;
            end else begin
                case (state)
                    S_RECV: begin
                        if (accept) begin
                            shreg     <= word_full ? '0 : shreg_next;
                            bit_cnt   <= bit_cnt_next;
                            crc       <= crc_next;
                            frame_len <= frame_len + LEN_W'(1);
                            if (word_full) begin
                                // an occupied, non-draining slot keeps its word; the new one is lost
                                if (slot_free) begin
                                    out_dat   <= shreg_next;
                                    out_nbits <= NB_W'(WORD_WIDTH);
                                    out_vld   <= 1'b1;
                                end else begin
                                    err_overrun <= 1'b1;
                                end
                            end
                        end else if (in_vld) begin
                            err_len <= 1'b1;
                        end
                        if (eof) begin
                            if (bit_cnt_next != '0) begin
                                state <= S_FLUSH;
                            end else begin
                                state      <= S_DONE;
                                frame_done <= 1'b1;
                                crc_ok     <= (crc_final == CRC_RESIDUE);
                            end
                        end
                    end
                    S_FLUSH: begin
                        if (slot_free) begin
                            out_dat    <= shreg << (NB_W'(WORD_WIDTH) - bit_cnt);
                            out_nbits  <= bit_cnt;
                            out_vld    <= 1'b1;
                            shreg      <= '0;
                            bit_cnt    <= '0;
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                            crc_ok     <= (crc == CRC_RESIDUE);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_assembler.sv
// tb/tb_rx_frame_assembler.sv - self-checking bench for rx_frame_assembler
module tb_rx_frame_assembler;

    localparam int MAX_A = 512;
    localparam int MAX_B = 16;
    localparam logic [15:0] POLY    = 16'h1021;
    localparam logic [15:0] INIT    = 16'hFFFF;
    localparam logic [15:0] RESIDUE = 16'h1D0F;

    logic       clk = 1'b0;
    logic       rst, sof, eof, in_dat, in_vld, out_rdy;
    logic [7:0] out_dat_a, out_dat_b;
    logic [3:0] out_nbits_a, out_nbits_b;
    logic       out_vld_a, out_vld_b, frame_done_a, frame_done_b;
    logic [9:0] frame_len_a;
    logic [4:0] frame_len_b;
    logic       crc_ok_a, crc_ok_b, err_len_a, err_len_b, err_overrun_a, err_overrun_b;

    int          checks = 0;
    int          errors = 0;
    int          done_a = 0;
    int          done_b = 0;
    logic [11:0] got_a[$];
    logic [11:0] got_b[$];
    logic [11:0] exp_q[$];
    bit          cur_bits[$];

    rx_frame_assembler #(.WORD_WIDTH(8), .MAX_BITS(MAX_A)) dut_a (
        .clk(clk), .rst(rst), .sof(sof), .eof(eof), .in_dat(in_dat), .in_vld(in_vld),
        .out_dat(out_dat_a), .out_nbits(out_nbits_a), .out_vld(out_vld_a), .out_rdy(out_rdy),
        .frame_done(frame_done_a), .frame_len(frame_len_a), .crc_ok(crc_ok_a),
        .err_len(err_len_a), .err_overrun(err_overrun_a)
    );

    rx_frame_assembler #(.WORD_WIDTH(8), .MAX_BITS(MAX_B)) dut_b (
        .clk(clk), .rst(rst), .sof(sof), .eof(eof), .in_dat(in_dat), .in_vld(in_vld),
        .out_dat(out_dat_b), .out_nbits(out_nbits_b), .out_vld(out_vld_b), .out_rdy(out_rdy),
        .frame_done(frame_done_b), .frame_len(frame_len_b), .crc_ok(crc_ok_b),
        .err_len(err_len_b), .err_overrun(err_overrun_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_vld_a && out_rdy) got_a.push_back({out_nbits_a, out_dat_a});
        if (out_vld_b && out_rdy) got_b.push_back({out_nbits_b, out_dat_b});
        if (frame_done_a) done_a++;
        if (frame_done_b) done_b++;
    end

    // CRC as the remainder of (bits * x^16 + INIT * x^n) mod G by long division
    function automatic logic [15:0] ref_crc(input int n);
        bit          a[$];
        logic [16:0] gen;
        logic [15:0] init_v;
        logic [15:0] r;
        gen    = {1'b1, POLY};
        init_v = INIT;
        for (int i = 0; i < n; i++) a.push_back(cur_bits[i]);
        repeat (16) a.push_back(1'b0);
        for (int i = 0; i < 16; i++) a[i] = a[i] ^ init_v[15-i];
        for (int i = 0; i < n; i++)
            if (a[i]) for (int j = 0; j <= 16; j++) a[i+j] = a[i+j] ^ gen[16-j];
        for (int i = 0; i < 16; i++) r[15-i] = a[n+i];
        return r;
    endfunction

    function automatic int accepted(input int maxb);
        return (cur_bits.size() > maxb) ? maxb : cur_bits.size();
    endfunction

    // expected words: accepted bits cut into 8-bit chunks, last chunk MSB-aligned
    function automatic void build_exp(input int maxb);
        int         n;
        int         k;
        logic [7:0] d;
        n = accepted(maxb);
        exp_q.delete();
        for (int i = 0; i < n; i += 8) begin
            k = (n - i >= 8) ? 8 : n - i;
            d = '0;
            for (int j = 0; j < k; j++) d[7-j] = cur_bits[i+j];
            exp_q.push_back({4'(k), d});
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_a.delete();
        got_b.delete();
        done_a = 0;
        done_b = 0;
    endtask

    task automatic send_frame(input int gap_max, input bit eof_last);
        clear_mon();
        sof = 1'b1;
        step();
        sof = 1'b0;
        foreach (cur_bits[i]) begin
            repeat ($urandom_range(gap_max, 0)) step();
            in_vld = 1'b1;
            in_dat = cur_bits[i];
            if (eof_last && i == cur_bits.size() - 1) eof = 1'b1;
            step();
            in_vld = 1'b0;
            eof    = 1'b0;
        end
        if (!eof_last || cur_bits.size() == 0) begin
            eof = 1'b1;
            step();
            eof = 1'b0;
        end
    endtask

    task automatic wait_done(input bit need_b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done_a > 0 && (!need_b || done_b > 0)) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; sof = 1'b1; eof = 1'b1; in_vld = 1'b1; in_dat = 1'b1; out_rdy = 1'b1;
        repeat (3) step();
        checks++;
        if ({out_dat_a, out_nbits_a, out_vld_a, frame_done_a, frame_len_a, crc_ok_a, err_len_a, err_overrun_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: outputs %h required 0", {out_dat_a, out_nbits_a, out_vld_a, frame_done_a, frame_len_a, crc_ok_a, err_len_a, err_overrun_a});
        end
        rst = 1'b0; sof = 1'b0; eof = 1'b0; in_vld = 1'b0; in_dat = 1'b0;
        step();
        checks++;
        if ({out_dat_b, out_nbits_b, out_vld_b, frame_done_b, frame_len_b, crc_ok_b, err_len_b, err_overrun_b} !== '0) begin
            errors++;
            $display("FAIL reset_idle_b: outputs %h required 0", {out_dat_b, out_nbits_b, out_vld_b, frame_done_b, frame_len_b, crc_ok_b, err_len_b, err_overrun_b});
        end
    endtask

    task automatic test_crc_vector();
        logic [7:0] msg[11];
        bit         ok;
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hD6, 8'h4E};
        cur_bits.delete();
        for (int i = 0; i < 11; i++)
            for (int j = 7; j >= 0; j--) cur_bits.push_back(msg[i][j]);
        out_rdy = 1'b1;
        send_frame(0, 1'b0);
        checks++;
        if (frame_done_a !== 1'b1) begin
            errors++;
            $display("FAIL vec_done_latency: frame_done %b required 1 one cycle after eof", frame_done_a);
        end
        wait_done(1'b0, ok);
        checks++;
        if (got_a.size() != 11 || done_a != 1) begin
            errors++;
            $display("FAIL vec_count: words %0d pulses %0d required 11 and 1", got_a.size(), done_a);
        end else begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (got_a[i] !== {4'd8, msg[i]}) begin
                    errors++;
                    $display("FAIL vec_word%0d: got %h required %h", i, got_a[i], {4'd8, msg[i]});
                end
            end
        end
        checks++;
        if ({frame_len_a, crc_ok_a, err_len_a, err_overrun_a} !== {10'd88, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL vec_status: len %0d crc_ok %b err_len %b err_ovr %b required 88 1 0 0", frame_len_a, crc_ok_a, err_len_a, err_overrun_a);
        end
        cur_bits[5] = ~cur_bits[5];
        build_exp(MAX_A);
        send_frame(0, 1'b0);
        wait_done(1'b0, ok);
        checks++;
        if (got_a != exp_q || crc_ok_a !== 1'b0 || frame_len_a !== 10'd88) begin
            errors++;
            $display("FAIL vec_corrupt: words %0d crc_ok %b len %0d required %0d 0 88", got_a.size(), crc_ok_a, frame_len_a, exp_q.size());
        end
    endtask

    task automatic test_partial_word();
        logic [12:0] v;
        bit          ok;
        v = 13'b1_0110_1001_0111;
        cur_bits.delete();
        for (int j = 12; j >= 0; j--) cur_bits.push_back(v[j]);
        send_frame(1, 1'b1);
        wait_done(1'b0, ok);
        checks++;
        if (ok !== 1'b1 || done_a != 1) begin
            errors++;
            $display("FAIL partial_done: seen %b pulses %0d required 1 1", ok, done_a);
        end
        checks++;
        if (got_a.size() != 2 || got_a[0] !== {4'd8, 8'hB4} || got_a[1] !== {4'd5, 8'hB8} || frame_len_a !== 10'd13) begin
            errors++;
            $display("FAIL partial_words: n %0d w0 %h w1 %h len %0d required 2 8b4 5b8 13", got_a.size(), got_a[0], got_a[1], frame_len_a);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] first;
        logic [7:0] tail;
        bit         ok;
        cur_bits.delete();
        for (int i = 0; i < 20; i++) cur_bits.push_back(1'($urandom));
        for (int i = 0; i < 8; i++) first[7-i] = cur_bits[i];
        tail = {cur_bits[16], cur_bits[17], cur_bits[18], cur_bits[19], 4'b0000};
        out_rdy = 1'b0;
        clear_mon();
        sof = 1'b1;
        step();
        sof = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_vld = 1'b1;
            in_dat = cur_bits[i];
            step();
            in_vld = 1'b0;
            if (i >= 7) begin
                checks++;
                if (out_vld_a !== 1'b1 || out_dat_a !== first || out_nbits_a !== 4'd8) begin
                    errors++;
                    $display("FAIL ovr_hold bit%0d: vld %b dat %h nbits %0d required 1 %h 8", i, out_vld_a, out_dat_a, out_nbits_a, first);
                end
            end
            if (i == 14 || i == 15) begin
                checks++;
                if (err_overrun_a !== (i == 15)) begin
                    errors++;
                    $display("FAIL ovr_flag bit%0d: err_overrun %b required %b", i, err_overrun_a, i == 15);
                end
            end
        end
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        checks++;
        if (out_vld_a !== 1'b0) begin
            errors++;
            $display("FAIL ovr_drain: out_vld %b required 0", out_vld_a);
        end
        eof = 1'b1;
        step();
        eof = 1'b0;
        step();
        checks++;
        if (out_vld_a !== 1'b1 || out_dat_a !== tail || out_nbits_a !== 4'd4) begin
            errors++;
            $display("FAIL ovr_flush: vld %b dat %h nbits %0d required 1 %h 4", out_vld_a, out_dat_a, out_nbits_a, tail);
        end
        out_rdy = 1'b1;
        wait_done(1'b0, ok);
        checks++;
        if (ok !== 1'b1 || got_a.size() != 2 || err_overrun_a !== 1'b1 || frame_len_a !== 10'd20) begin
            errors++;
            $display("FAIL ovr_end: done %b words %0d err_ovr %b len %0d required 1 2 1 20", ok, got_a.size(), err_overrun_a, frame_len_a);
        end
    endtask

    task automatic test_max_len();
        bit ok;
        cur_bits.delete();
        repeat (16) cur_bits.push_back(1'b0);
        repeat (4) cur_bits.push_back(1'b1);
        send_frame(0, 1'b0);
        wait_done(1'b1, ok);
        checks++;
        if (ok !== 1'b1 || frame_len_b !== 5'd16 || err_len_b !== 1'b1 || crc_ok_b !== 1'b1 || err_overrun_b !== 1'b0) begin
            errors++;
            $display("FAIL maxlen_status: done %b len %0d err_len %b crc_ok %b err_ovr %b required 1 16 1 1 0", ok, frame_len_b, err_len_b, crc_ok_b, err_overrun_b);
        end
        checks++;
        if (got_b.size() != 2 || got_b[0] !== 12'h800 || got_b[1] !== 12'h800) begin
            errors++;
            $display("FAIL maxlen_words: n %0d w0 %h w1 %h required 2 800 800", got_b.size(), got_b[0], got_b[1]);
        end
        checks++;
        if (frame_len_a !== 10'd20 || err_len_a !== 1'b0) begin
            errors++;
            $display("FAIL maxlen_wide: len %0d err_len %b required 20 0", frame_len_a, err_len_a);
        end
    endtask

    task automatic test_abort_and_reset();
        bit ok;
        out_rdy = 1'b0;
        sof = 1'b1;
        step();
        sof = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_vld = 1'b1;
            in_dat = 1'($urandom);
            step();
        end
        in_vld = 1'b0;
        checks++;
        if (out_vld_a !== 1'b1 || frame_len_a !== 10'd10) begin
            errors++;
            $display("FAIL abort_pre: out_vld %b len %0d required 1 10", out_vld_a, frame_len_a);
        end
        clear_mon();
        sof = 1'b1; in_vld = 1'b1; in_dat = 1'b1; eof = 1'b1;
        step();
        sof = 1'b0; in_vld = 1'b0; eof = 1'b0;
        checks++;
        if (out_vld_a !== 1'b0 || frame_len_a !== 10'd0 || frame_done_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_sof: out_vld %b len %0d done %b required 0 0 0", out_vld_a, frame_len_a, frame_done_a);
        end
        out_rdy = 1'b1;
        cur_bits.delete();
        repeat (16) cur_bits.push_back(1'b0);
        foreach (cur_bits[i]) begin
            in_vld = 1'b1;
            in_dat = cur_bits[i];
            step();
        end
        in_vld = 1'b0;
        eof = 1'b1;
        step();
        eof = 1'b0;
        wait_done(1'b0, ok);
        checks++;
        if (ok !== 1'b1 || done_a != 1 || frame_len_a !== 10'd16 || crc_ok_a !== 1'b1 || got_a.size() != 2) begin
            errors++;
            $display("FAIL abort_restart: done %b pulses %0d len %0d crc_ok %b words %0d required 1 1 16 1 2", ok, done_a, frame_len_a, crc_ok_a, got_a.size());
        end
        out_rdy = 1'b0;
        sof = 1'b1;
        step();
        sof = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_vld = 1'b1;
            in_dat = 1'($urandom);
            step();
        end
        in_vld = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_vld = 1'b0;
        checks++;
        if ({out_dat_a, out_nbits_a, out_vld_a, frame_done_a, frame_len_a, crc_ok_a, err_len_a, err_overrun_a,
             out_dat_b, out_nbits_b, out_vld_b, frame_done_b, frame_len_b, crc_ok_b, err_len_b, err_overrun_b} !== '0) begin
            errors++;
            $display("FAIL midframe_rst: a %h b %h required 0", {out_dat_a, out_nbits_a, out_vld_a, frame_len_a, err_len_a, err_overrun_a},
                     {out_dat_b, out_nbits_b, out_vld_b, frame_len_b, err_len_b, err_overrun_b});
        end
        out_rdy = 1'b1;
    endtask

    task automatic test_random_frames();
        bit ok;
        int n;
        int n_a;
        int n_b;
        for (int f = 0; f < 10; f++) begin
            n = $urandom_range(40, 0);
            cur_bits.delete();
            for (int i = 0; i < n; i++) cur_bits.push_back(1'($urandom));
            out_rdy = 1'b1;
            send_frame(2, 1'($urandom));
            wait_done(1'b1, ok);
            for (int i = 0; i < 3; i++) begin
                in_vld = 1'b1;
                in_dat = 1'($urandom);
                eof    = 1'b1;
                step();
            end
            in_vld = 1'b0;
            eof    = 1'b0;
            step();
            step();
            n_a = accepted(MAX_A);
            n_b = accepted(MAX_B);
            build_exp(MAX_A);
            checks++;
            if (ok !== 1'b1 || done_a != 1 || got_a != exp_q || frame_len_a !== 10'(n_a) ||
                crc_ok_a !== (ref_crc(n_a) == RESIDUE) || err_len_a !== 1'b0 || err_overrun_a !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_a: n %0d done %b pulses %0d words %0d/%0d len %0d crc_ok %b err %b%b", f, n, ok, done_a,
                         got_a.size(), exp_q.size(), frame_len_a, crc_ok_a, err_len_a, err_overrun_a);
            end
            build_exp(MAX_B);
            checks++;
            if (done_b != 1 || got_b != exp_q || frame_len_b !== 5'(n_b) || crc_ok_b !== (ref_crc(n_b) == RESIDUE) ||
                err_len_b !== (n > MAX_B) || err_overrun_b !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_b: n %0d pulses %0d words %0d/%0d len %0d crc_ok %b err %b%b", f, n, done_b,
                         got_b.size(), exp_q.size(), frame_len_b, crc_ok_b, err_len_b, err_overrun_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_crc_vector();
        test_partial_word();
        test_overrun();
        test_max_len();
        test_abort_and_reset();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_frame_assembler.md
Name: rx_frame_assembler

Overview:
Parametrised RX frame back-end between the bit detector and the control FSM. It takes the serial decoded bit stream, delimited by the start-of-frame and end-of-frame strobes from the preamble detector. It packs bits MSB-first into WORD_WIDTH words behind a valid/ready handshake and runs a parametrised serial CRC for residue checking. At end-of-frame it reports frame length, CRC result and error flags, replacing the fixed-width crc16 instance on the RX path.

Parameters:
WORD_WIDTH, 8, output word width in bits (>=2)
MAX_BITS, 512, maximum accepted frame length in bits; excess bits are dropped
CRC_WIDTH, 16, CRC register width (>=3)
CRC_POLY, 16'h1021, generator polynomial, implicit x^CRC_WIDTH term omitted
CRC_INIT, 16'hFFFF, CRC register value loaded on sof
CRC_RESIDUE, 16'h1D0F, CRC register value that indicates a good frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sof  in  1  start-of-frame strobe; aborts and restarts from any state
eof  in  1  end-of-frame strobe
in_dat  in  1  decoded bit
in_vld  in  1  in_dat qualifier
out_dat  out  WORD_WIDTH  packed word; first received bit in MSB
out_nbits  out  $clog2(WORD_WIDTH+1)  number of valid bits in out_dat, MSB-aligned
out_vld  out  1  word valid
out_rdy  in  1  downstream accepts word
frame_done  out  1  single-cycle pulse: frame finished, status valid
frame_len  out  $clog2(MAX_BITS+1)  accepted bit count
crc_ok  out  1  CRC register equals CRC_RESIDUE at end of frame
err_len  out  1  sticky: bits arrived after MAX_BITS
err_overrun  out  1  sticky: word completed while output slot occupied

Behaviour:
- Reset: all outputs 0, state IDLE, CRC register = CRC_INIT, counters and shift register 0. rst has priority over every other input.
- States:
  - IDLE, RECV, FLUSH, DONE.
  - sof in any state -> RECV next cycle. Clears the shift register, bit/word counters, frame_len, err_len and err_overrun, and loads CRC_INIT.
  - sof drops any pending output word (out_vld=0).
  - An in_vld in the sof cycle is discarded. sof with eof in the same cycle: sof wins, eof is ignored.
- RECV, in_vld=1 with frame_len<MAX_BITS:
  - Shift the bit into the shift register and increment frame_len.
  - CRC update, MSB-first: fb = crc[CRC_WIDTH-1]^in_dat; crc <= {crc[CRC_WIDTH-2:0],1'b0} ^ (fb ? CRC_POLY : 0).
- RECV, in_vld=1 with frame_len==MAX_BITS: bit dropped, CRC and frame_len unchanged, err_len set.
- Word completion:
  - When the WORD_WIDTH-th bit of a word is shifted in, the word is loaded to out_dat with out_nbits=WORD_WIDTH. out_vld rises the next cycle (latency 1).
  - If out_vld=1 and out_rdy=0 in the completion cycle, the new word is dropped and err_overrun is set. The held word is unchanged.
  - If out_vld=1 and out_rdy=1 in the completion cycle, the new word replaces it with no bubble.
- Handshake:
  - out_dat and out_nbits are stable while out_vld=1 and out_rdy=0.
  - Transfer occurs when out_vld and out_rdy are both high. out_vld drops next cycle unless a new word loads.
- eof in RECV:
  - A bit with in_vld in the eof cycle is included first.
  - Partial word pending (k bits, 0<k<WORD_WIDTH): go to FLUSH. The partial word is loaded MSB-aligned, zero-padded, with out_nbits=k, as soon as the slot is free (out_vld=0, or transfer this cycle). Then go to DONE.
  - No partial word pending: go directly to DONE.
- DONE:
  - frame_done pulses for exactly 1 cycle on entry, then state returns to IDLE.
  - frame_len, crc_ok, err_len and err_overrun hold until the next sof or rst.
  - crc_ok is computed from the final CRC register; it is 0 for a zero-length frame unless CRC_INIT==CRC_RESIDUE.
- Latency: eof with no partial word and no pending data -> frame_done at eof+1.
- Ignored inputs: eof in IDLE or DONE; in_vld outside RECV.

Test Plan:
1. WORD_WIDTH=8, sof, ASCII "123456789" MSB-first then 0xD6,0x4E (88 bits), eof, out_rdy=1 -> words 0x31..0x39,0xD6,0x4E each with out_nbits=8; frame_done 1 cycle after eof; frame_len=88; crc_ok=1; both error flags 0.
2. Same frame with bit 5 inverted -> crc_ok=0, frame_len=88.
3. 13 bits 1_0110_1001_0111 then eof, out_rdy=1 -> words 0xB4 (nbits 8) and 0xB8 (nbits 5, zero-padded); frame_done after the partial word loads; frame_len=13.
4. out_rdy=0 for 20 bits -> first word held stable; second completion sets err_overrun=1; held word is still the first; then out_rdy=1 -> transfer and out_vld=0.
5. MAX_BITS=16, send 20 bits then eof -> frame_len=16, err_len=1, exactly 2 words out, CRC covers only the first 16 bits.
6. sof mid-frame after 10 bits with a word pending, plus an in_vld in the sof cycle -> out_vld=0, frame_len=0, CRC=CRC_INIT, and the sof-cycle bit is not counted. rst asserted mid-frame -> all outputs 0 next cycle.
